// File: rtl/shreg_pkg.sv
// Shared definitions for the shreg_ctrl serializer slice.
//   state_e   : controller FSM state encoding
//   DWIDTH_DEF: default parallel word width
//   lenw_of() : width of the bit-count input for a given word width
package shreg_pkg;

  localparam int unsigned DWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Wide enough to hold the value DWIDTH itself.
  function automatic int unsigned lenw_of(input int unsigned dw);
    return $clog2(dw) + 1;
  endfunction

endpackage

// File: rtl/shreg_piso.sv
// Parallel-in/serial-out datapath for shreg_ctrl.
//   i_clk, i_rst     : clock, async active-high reset
//   i_load           : capture i_data/i_len/i_msb_first (handshake cycle)
//   i_shift          : advance one bit
//   i_data           : parallel word
//   i_len            : requested bit count (0 or >DWIDTH means DWIDTH)
//   i_msb_first      : 1 = MSB of the payload first
//   o_load_bit       : first payload bit of the word being loaded
//   o_shift_bit      : bit that becomes current after the next shift
//   o_last           : current bit is the final payload bit
module shreg_piso
  import shreg_pkg::*;
#(
  parameter  int unsigned DWIDTH = DWIDTH_DEF,
  localparam int unsigned LENW   = lenw_of(DWIDTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DWIDTH-1:0] i_data,
  input  logic [LENW-1:0]   i_len,
  input  logic              i_msb_first,
  output logic              o_load_bit,
  output logic              o_shift_bit,
  output logic              o_last
);

  localparam logic [LENW-1:0] DW_L = LENW'(DWIDTH);

  logic [DWIDTH-1:0] sreg_q, sreg_d;
  logic [DWIDTH-1:0] aligned;
  logic [LENW-1:0]   cnt_q, cnt_d;
  logic [LENW-1:0]   len_eff;
  logic              msb_q, msb_d;

  always_comb begin
    len_eff = ((i_len == '0) || (i_len > DW_L)) ? DW_L : i_len;
    // MSB-first words are left-justified so the payload MSB sits at the
    // top; bits above len are never shifted out, so no masking is needed.
    aligned     = i_msb_first ? (i_data << (DW_L - len_eff)) : i_data;
    o_load_bit  = i_msb_first ? aligned[DWIDTH-1] : aligned[0];
    o_shift_bit = msb_q ? sreg_q[DWIDTH-2] : sreg_q[1];
    o_last      = (cnt_q == '0);

    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    msb_d  = msb_q;
    if (i_load) begin
      sreg_d = aligned;
      cnt_d  = len_eff - LENW'(1);
      msb_d  = i_msb_first;
    end else if (i_shift) begin
      sreg_d = msb_q ? {sreg_q[DWIDTH-2:0], 1'b0} : {1'b0, sreg_q[DWIDTH-1:1]};
      if (cnt_q != '0) cnt_d = cnt_q - LENW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      msb_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      msb_q  <= msb_d;
    end
  end

endmodule

// File: rtl/shreg_ctrl.sv
// Serializer controller: accepts a parallel word over valid/ready and
// shifts it out one bit per clock, then pulses o_done for one cycle.
//   i_clk, i_rst   : clock, async active-high reset
//   i_data         : parallel word (sampled at handshake)
//   i_valid/o_ready: input handshake
//   i_len          : bit count (0 or >DWIDTH means DWIDTH)
//   i_msb_first    : bit order, 1 = MSB first
//   o_q/o_q_valid  : serial bit and its qualifier (o_q=0 when not valid)
//   o_busy         : word in flight
//   o_done         : one-cycle completion pulse
// All outputs are registered.
module shreg_ctrl
  import shreg_pkg::*;
#(
  parameter  int unsigned DWIDTH = DWIDTH_DEF,
  localparam int unsigned LENW   = lenw_of(DWIDTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [LENW-1:0]   i_len,
  input  logic              i_msb_first,
  output logic              o_q,
  output logic              o_q_valid,
  output logic              o_busy,
  output logic              o_done
);

  state_e state_q, state_d;
  logic   ser_q, ser_d;
  logic   ser_vld_q, ser_vld_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   ready_q, ready_d;

  logic   hs;
  logic   load_bit, shift_bit, last;
  logic   do_shift;

  shreg_piso #(.DWIDTH(DWIDTH)) u_piso (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (hs),
    .i_shift     (do_shift),
    .i_data      (i_data),
    .i_len       (i_len),
    .i_msb_first (i_msb_first),
    .o_load_bit  (load_bit),
    .o_shift_bit (shift_bit),
    .o_last      (last)
  );

  always_comb begin
    hs       = (state_q == IDLE) && i_valid && ready_q;
    do_shift = (state_q == SHIFT) && !last;
    state_d  = state_q;
    ser_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = SHIFT;
          ser_d   = load_bit;
        end
      end
      SHIFT: begin
        if (last) state_d = DONE;
        else      ser_d   = shift_bit;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered images of the next state.
    ser_vld_d = (state_d == SHIFT);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    ready_d   = (state_d == IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      ser_q     <= 1'b0;
      ser_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ser_q     <= ser_d;
      ser_vld_q <= ser_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign o_q       = ser_q;
  assign o_q_valid = ser_vld_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_ready   = ready_q;

endmodule

// File: tb/tb_shreg_ctrl.sv
// Self-checking bench for shreg_ctrl (DWIDTH=8).
module tb_shreg_ctrl;
  import shreg_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = lenw_of(DW);

  logic          i_clk;
  logic          i_rst;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic [LW-1:0] i_len;
  logic          i_msb_first;
  logic          o_q;
  logic          o_q_valid;
  logic          o_busy;
  logic          o_done;

  shreg_ctrl #(.DWIDTH(DW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_len       (i_len),
    .i_msb_first (i_msb_first),
    .o_q         (o_q),
    .o_q_valid   (o_q_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  bit          exp_q[$];
  bit          prev_valid = 1'b0;
  bit          prev_done  = 1'b0;

  always @(posedge i_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected serial bit sequence of one word.
  function automatic void push_word(input logic [7:0] d, input int unsigned len, input bit msb);
    int unsigned l;
    l = (len == 0 || len > DW) ? DW : len;
    for (int unsigned k = 0; k < l; k++)
      exp_q.push_back(msb ? d[l-1-k] : d[k]);
  endfunction

  // Monitor: compares every serial bit and the framing around it.
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (o_q_valid) begin
        if (exp_q.size() == 0) check("unexpected_bit", 32'd1, 32'd0);
        else                   check("serial_bit", 32'(o_q), 32'(exp_q.pop_front()));
      end else begin
        check("idle_line", 32'(o_q), 32'd0);
      end
      check("done_pulse", 32'(o_done), 32'(prev_valid && !o_q_valid));
      check("busy", 32'(o_busy), 32'(o_q_valid || o_done));
      if (prev_done) check("ready_after_done", 32'(o_ready), 32'd1);
      if (o_done)    check("word_complete", exp_q.size(), 32'd0);
      prev_valid = o_q_valid;
      prev_done  = o_done;
    end
  end

  // Called #1 after an edge; returns the cycle stamp of the handshake edge.
  task automatic send(input logic [7:0] d, input logic [LW-1:0] len, input bit msb,
                      input bit hold, input bit scramble, output int unsigned hs_cyc);
    int unsigned t = 0;
    i_data = d; i_len = len; i_msb_first = msb; i_valid = 1'b1;
    while (!o_ready && t < 200) begin
      @(posedge i_clk); #1; t++;
      if (scramble) begin
        i_data = DW'($urandom); i_len = LW'($urandom); i_msb_first = 1'($urandom);
      end
    end
    if (!o_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      hs_cyc  = 0;
      i_valid = 1'b0;
      return;
    end
    i_data = d; i_len = len; i_msb_first = msb;
    push_word(d, int'(len), msb);
    @(posedge i_clk); #1;
    hs_cyc = cyc;
    if (!hold) i_valid = 1'b0;
    if (scramble) begin
      i_data = DW'($urandom); i_len = LW'($urandom); i_msb_first = 1'($urandom);
    end
  endtask

  task automatic wait_done(output int unsigned c);
    int unsigned t = 0;
    while (!o_done && t < 100) begin @(posedge i_clk); #1; t++; end
    if (!o_done) check("done_timeout", 32'd0, 32'd1);
    c = cyc;
  endtask

  task automatic wait_idle();
    int unsigned t = 0;
    while (!o_ready && t < 100) begin @(posedge i_clk); #1; t++; end
    if (!o_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_q"},     32'(o_q),       32'd0);
    check({name, "_valid"}, 32'(o_q_valid), 32'd0);
    check({name, "_busy"},  32'(o_busy),    32'd0);
    check({name, "_done"},  32'(o_done),    32'd0);
    check({name, "_ready"}, 32'(o_ready),   32'd0);
  endtask

  task automatic directed(input logic [7:0] d, input logic [LW-1:0] len, input bit msb,
                          input int unsigned exp_len);
    int unsigned h, c;
    send(d, len, msb, 1'b0, 1'b0, h);
    wait_done(c);
    check("done_latency", c - h, exp_len);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned h1, h2, c;
    i_rst = 1'b0; i_valid = 1'b0; i_data = '0; i_len = '0; i_msb_first = 1'b0;

    // Reset asserted between edges, released mid-cycle.
    #2 i_rst = 1'b1;
    #1 check_all_zero("reset");
    @(posedge i_clk); @(posedge i_clk);
    #3 i_rst = 1'b0;
    #1 check("ready_before_edge", 32'(o_ready), 32'd0);
    @(posedge i_clk); #1;
    check("ready_after_release", 32'(o_ready), 32'd1);
    check("valid_after_release", 32'(o_q_valid), 32'd0);
    check("q_after_release", 32'(o_q), 32'd0);

    // Directed words.
    directed(8'hC4, LW'(8), 1'b1, 8);
    directed(8'hC4, LW'(8), 1'b0, 8);
    directed(8'hFD, LW'(3), 1'b1, 3);
    directed(8'hFD, LW'(0), 1'b1, 8);
    directed(8'h6B, LW'(1), 1'b0, 1);
    directed(8'h96, LW'(12), 1'b0, 8);

    // Back-to-back with inputs churning during the shift.
    send(8'h5A, LW'(8), 1'b1, 1'b1, 1'b1, h1);
    send(8'h3C, LW'(5), 1'b0, 1'b0, 1'b1, h2);
    check("b2b_gap", h2 - h1, 32'd10);
    wait_idle();

    // Reset after three bits of an 8-bit word.
    send(8'hA7, LW'(8), 1'b1, 1'b0, 1'b0, h1);
    @(posedge i_clk);
    @(posedge i_clk);
    #6 i_rst = 1'b1;
    #1 check_all_zero("midreset");
    exp_q.delete();
    repeat (3) begin
      @(posedge i_clk); #1;
      check("midreset_no_done", 32'(o_done), 32'd0);
    end
    #2 i_rst = 1'b0;
    #1 check("midreset_ready_before_edge", 32'(o_ready), 32'd0);
    @(posedge i_clk); #1;
    check("midreset_ready", 32'(o_ready), 32'd1);
    directed(8'h81, LW'(8), 1'b1, 8);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      logic [7:0]    d;
      logic [LW-1:0] l;
      bit            m, s;
      int unsigned   gap, el;
      d   = 8'($urandom);
      l   = LW'($urandom);
      m   = 1'($urandom);
      s   = 1'($urandom);
      gap = $urandom_range(0, 3);
      el  = (l == 0 || l > DW) ? DW : int'(l);
      repeat (gap) begin @(posedge i_clk); #1; end
      send(d, l, m, 1'b0, s, h1);
      if ((i % 4) == 0) begin
        wait_done(c);
        check("rand_done_latency", c - h1, el);
      end
    end
    wait_idle();
    @(posedge i_clk); #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
